// File: rtl/top_varint_decode.sv
// -----------------------------------------------------------------------------
// top_varint_decode
//
// Decodes one protobuf base-128 varint (1..10 bytes) fetched from a byte-wide,
// 8-lane DRAM port. Byte k of the varint lives at src_addr-k. The first eight
// bytes are fetched with one 8-lane burst. If none of them terminates the
// varint, a second 2-lane burst fetches bytes 8 and 9. The raw value is then
// post-processed according to the protobuf field type.
//
// The result path is a two-stage pipeline once the bytes are captured:
//   stage 1 : terminator scan + 7-bit group assembly -> raw/length/error regs
//   stage 2 : field-type decode -> registered value/bytes_read/error/done
//
// Ports
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset
//   en          : start request (sampled in IDLE), hold request (in DONE)
//   src_addr    : address of varint byte 0
//   field_type  : protobuf field type code (17 sint32, 18 sint64, 5 int32,
//                 13 uint32, 8 bool, others raw)
//   dram_en     : per-lane read strobe
//   dram_addr   : per-lane byte address
//   dram_rdwr   : direction, always 0 (read)
//   dram_data   : per-lane read data
//   dram_valid  : per-lane read-data valid
//   value       : decoded value
//   bytes_read  : bytes consumed (1..10)
//   done        : result valid
//   error       : no terminator within 10 bytes
// -----------------------------------------------------------------------------
module top_varint_decode (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [63:0]      src_addr,
    input  logic [4:0]       field_type,
    output logic [7:0]       dram_en,
    output logic [7:0][63:0] dram_addr,
    output logic             dram_rdwr,
    input  logic [7:0][7:0]  dram_data,
    input  logic [7:0]       dram_valid,
    output logic [63:0]      value,
    output logic [3:0]       bytes_read,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD1   = 3'd1,
        WAIT1 = 3'd2,
        RD2   = 3'd3,
        WAIT2 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t          state_r;
    state_t          state_s;

    logic [63:0]     src_addr_r;
    logic [4:0]      field_type_r;
    logic [9:0][7:0] bytes_r;
    logic            phase_r;       // 0: assemble raw, 1: publish result
    logic [63:0]     raw_r;
    logic [3:0]      n_r;
    logic            err_r;

    logic            term_in_burst1_s;
    logic [63:0]     raw_s;
    logic [3:0]      n_s;
    logic            err_s;
    logic            found_s;

    // Field-type post-processing of the assembled raw value.
    function automatic logic [63:0] decode_value(input logic [63:0] raw,
                                                 input logic [4:0]  ft);
        logic [31:0] r32;
        logic [31:0] z32;
        logic [63:0] res;
        r32 = raw[31:0];
        // zigzag: (r >> 1) ^ -(r & 1)
        z32 = (r32 >> 1) ^ {32{r32[0]}};
        case (ft)
            5'd17:   res = {{32{z32[31]}}, z32};
            5'd18:   res = (raw >> 1) ^ {64{raw[0]}};
            5'd5:    res = {{32{raw[31]}}, raw[31:0]};
            5'd13:   res = {32'd0, raw[31:0]};
            5'd8:    res = {63'd0, (raw != 64'd0)};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign dram_rdwr = 1'b0;

    // Terminator present among the eight bytes arriving in the first burst.
    always_comb begin
        term_in_burst1_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!dram_data[i][7]) begin
                term_in_burst1_s = 1'b1;
            end else begin
                term_in_burst1_s = term_in_burst1_s;
            end
        end
    end

    // Terminator scan and 7-bit group assembly over the captured bytes.
    always_comb begin
        n_s     = 4'd10;
        err_s   = 1'b1;
        found_s = 1'b0;
        raw_s   = 64'd0;
        for (int k = 0; k < 10; k++) begin
            if (!found_s && !bytes_r[k][7]) begin
                n_s     = 4'(k + 1);
                err_s   = 1'b0;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        // Byte 9 shifted by 63 leaves only its bit 0 inside 64 bits.
        for (int k = 0; k < 10; k++) begin
            if (4'(k) < n_s) begin
                raw_s = raw_s | ({57'd0, bytes_r[k][6:0]} << (7 * k));
            end else begin
                raw_s = raw_s;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) state_s = RD1;
                else    state_s = IDLE;
            end
            RD1: state_s = WAIT1;
            WAIT1: begin
                if (dram_valid == 8'hFF) begin
                    if (term_in_burst1_s) state_s = DONE;
                    else                  state_s = RD2;
                end else begin
                    state_s = WAIT1;
                end
            end
            RD2: state_s = WAIT2;
            WAIT2: begin
                if (dram_valid[1:0] == 2'b11) state_s = DONE;
                else                          state_s = WAIT2;
            end
            DONE: begin
                // Leave only once the result has actually been published.
                if (done && !en) state_s = IDLE;
                else             state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_s;
    end

    // Request issue, byte capture, result pipeline and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dram_en      <= 8'h00;
            dram_addr    <= 512'd0;
            src_addr_r   <= 64'd0;
            field_type_r <= 5'd0;
            bytes_r      <= 80'd0;
            phase_r      <= 1'b0;
            raw_r        <= 64'd0;
            n_r          <= 4'd0;
            err_r        <= 1'b0;
            value        <= 64'd0;
            bytes_read   <= 4'd0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // Strobes are single-cycle; addresses return to zero when idle.
            dram_en   <= 8'h00;
            dram_addr <= 512'd0;
            case (state_r)
                IDLE: begin
                    if (en) begin
                        src_addr_r   <= src_addr;
                        field_type_r <= field_type;
                        bytes_r      <= 80'd0;
                        dram_en      <= 8'hFF;
                        for (int i = 0; i < 8; i++) begin
                            dram_addr[i] <= src_addr - 64'(i);
                        end
                    end else begin
                        bytes_r <= bytes_r;
                    end
                end
                WAIT1: begin
                    if (dram_valid == 8'hFF) begin
                        for (int i = 0; i < 8; i++) begin
                            bytes_r[i] <= dram_data[i];
                        end
                        if (!term_in_burst1_s) begin
                            dram_en      <= 8'h03;
                            dram_addr[0] <= src_addr_r - 64'd8;
                            dram_addr[1] <= src_addr_r - 64'd9;
                        end else begin
                            dram_en <= 8'h00;
                        end
                    end else begin
                        bytes_r <= bytes_r;
                    end
                end
                WAIT2: begin
                    if (dram_valid[1:0] == 2'b11) begin
                        bytes_r[8] <= dram_data[0];
                        bytes_r[9] <= dram_data[1];
                    end else begin
                        bytes_r <= bytes_r;
                    end
                end
                DONE: begin
                    if (!phase_r) begin
                        raw_r   <= raw_s;
                        n_r     <= n_s;
                        err_r   <= err_s;
                        phase_r <= 1'b1;
                    end else if (!done) begin
                        value      <= err_r ? 64'd0 : decode_value(raw_r, field_type_r);
                        bytes_read <= n_r;
                        error      <= err_r;
                        done       <= 1'b1;
                    end else if (!en) begin
                        done    <= 1'b0;
                        phase_r <= 1'b0;
                    end else begin
                        done <= done;
                    end
                end
                default: begin
                    phase_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_varint_decode.sv
// -----------------------------------------------------------------------------
// Bench for top_varint_decode. A 1-cycle memory model answers DRAM requests.
// Each request pushes its hand-computed expected result onto a queue; a
// monitor pops and compares on every rising edge of done.
// -----------------------------------------------------------------------------
module tb_top_varint_decode;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [63:0]      src_addr;
    logic [4:0]       field_type;
    logic [7:0]       dram_en;
    logic [7:0][63:0] dram_addr;
    logic             dram_rdwr;
    logic [7:0][7:0]  dram_data = 64'd0;
    logic [7:0]       dram_valid = 8'h00;
    logic [63:0]      value;
    logic [3:0]       bytes_read;
    logic             done;
    logic             error;

    typedef struct {
        logic [63:0] val;
        logic [3:0]  n;
        logic        err;
        logic        rd2;
        int          lat;
        int          start;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  mem [0:511];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        done_q = 1'b0;
    logic        rd2_seen = 1'b0;
    logic [63:0] cur_src = 64'd0;

    top_varint_decode dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .src_addr   (src_addr),
        .field_type (field_type),
        .dram_en    (dram_en),
        .dram_addr  (dram_addr),
        .dram_rdwr  (dram_rdwr),
        .dram_data  (dram_data),
        .dram_valid (dram_valid),
        .value      (value),
        .bytes_read (bytes_read),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: a request seen at an edge is answered at that edge, valid for the next cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            dram_valid[i] <= dram_en[i];
            dram_data[i]  <= mem[dram_addr[i][8:0]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: checks request addresses and scores every published result.
    always @(negedge clk) begin
        if (dram_en == 8'hFF) begin
            chk("rd1_lane0_addr", dram_addr[0], cur_src);
            chk("rd1_lane7_addr", dram_addr[7], cur_src - 64'd7);
        end
        if (dram_en == 8'h03) begin
            rd2_seen = 1'b1;
            chk("rd2_lane0_addr", dram_addr[0], cur_src - 64'd8);
            chk("rd2_lane1_addr", dram_addr[1], cur_src - 64'd9);
            chk("rd2_lane2_addr", dram_addr[2], 64'd0);
        end
        if (!reset && done && !done_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("value", value, mon_e.val);
                chk("bytes_read", {60'd0, bytes_read}, {60'd0, mon_e.n});
                chk("error", {63'd0, error}, {63'd0, mon_e.err});
                chk("rd2_issued", {63'd0, rd2_seen}, {63'd0, mon_e.rd2});
                chk("latency", 64'(cyc - mon_e.start), 64'(mon_e.lat));
                rd2_seen = 1'b0;
            end
        end
        done_q = done;
    end

    // Loads the varint bytes (byte 0 in bits 7:0) below src, clearing the rest.
    task automatic set_bytes(input logic [63:0] src, input logic [79:0] b);
        logic [63:0] a;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        for (int k = 0; k < 10; k++) begin
            a = src - 64'(k);
            mem[a[8:0]] = b[8*k +: 8];
        end
    endtask

    task automatic req(input logic [63:0] src, input logic [4:0] ft,
                       input logic [63:0] v, input logic [3:0] n,
                       input logic err, input logic rd2, input logic hold);
        exp_t e;
        int   k;
        @(negedge clk);
        cur_src    = src;
        src_addr   = src;
        field_type = ft;
        en         = 1'b1;
        @(posedge clk);
        #1;
        e.val   = v;
        e.n     = n;
        e.err   = err;
        e.rd2   = rd2;
        e.lat   = rd2 ? 6 : 4;
        e.start = cyc;
        sb.push_back(e);
        if (!hold) en = 1'b0;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        if (hold) begin
            repeat (3) @(negedge clk);
            chk("done_held", {63'd0, done}, 64'd1);
            en = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("done_cleared", {63'd0, done}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        reset      = 1'b1;
        en         = 1'b0;
        src_addr   = 64'd0;
        field_type = 5'd0;
        #2;
        chk("reset_value", value, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_dram_en", {56'd0, dram_en}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        set_bytes(64'h100, 80'h0196);
        req(64'h100, 5'd4, 64'd150, 4'd2, 1'b0, 1'b0, 1'b0);
        set_bytes(64'h100, 80'h0F_FFFF_FFFF);
        req(64'h100, 5'd13, 64'h0000_0000_FFFF_FFFF, 4'd5, 1'b0, 1'b0, 1'b0);
        req(64'h100, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 1'b0, 1'b0, 1'b0);
        set_bytes(64'h100, 80'h0196);
        req(64'h100, 5'd8, 64'd1, 4'd2, 1'b0, 1'b0, 1'b1);
        set_bytes(64'h100, 80'h01_FFFF_FFFF_FFFF_FFFF_FF);
        req(64'h100, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0, 1'b1, 1'b0);
        set_bytes(64'h100, {10{8'hFF}});
        req(64'h100, 5'd3, 64'd0, 4'd10, 1'b1, 1'b1, 1'b0);
        set_bytes(64'h100, 80'h03);
        req(64'h100, 5'd17, 64'hFFFF_FFFF_FFFF_FFFE, 4'd1, 1'b0, 1'b0, 1'b0);
        req(64'h100, 5'd18, 64'hFFFF_FFFF_FFFF_FFFE, 4'd1, 1'b0, 1'b0, 1'b0);

        // Reset in WAIT1: outputs clear at once, request is abandoned.
        set_bytes(64'h100, 80'h0196);
        @(negedge clk);
        cur_src  = 64'h100;
        src_addr = 64'h100;
        field_type = 5'd4;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_value", value, 64'd0);
        chk("midreset_bytes_read", {60'd0, bytes_read}, 64'd0);
        chk("midreset_done_error", {62'd0, done, error}, 64'd0);
        chk("midreset_dram_en", {56'd0, dram_en}, 64'd0);
        chk("midreset_dram_addr0", dram_addr[0], 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("midreset_no_done", {63'd0, done}, 64'd0);
        req(64'h100, 5'd4, 64'd150, 4'd2, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
